mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multi-cycle control unit for the 19-bit-instruction MIPS datapath. It latches each fetched instruction, decodes it and steps it through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. Each state drives the datapath control lines, and every register, memory, stack and PC write is gated to exactly one cycle per instruction. It sits beside the datapath, which gains a `pc_write` enable. It adds run gating, HALT and a sticky stack-fault stop.

## Interface
Parameters:
- none (encodings are fixed in the shared package)

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  level; when 0, no new instruction starts (sampled in FETCH only).
- `instruction`  in  19  current instruction from the datapath (valid during FETCH).
- `zero`  in  1  ALU zero from the datapath.
- `stack_overflow`  in  1  stack over/underflow, valid in the push/pop cycle.
- `pc_write`  out  1  PC update enable, one cycle per retired instruction.
- `pc_src`  out  2  00 pc+1, 01 absolute [11:0], 10 stack top, 11 pc+1+sext([7:0]).
- `reg2_read_source`, `branch`, `mem_read_write`, `mem_or_alu`, `is_shift`, `alu_src`, `reg_read_write`, `stack_push`, `stack_pop`  out  1 each  datapath controls.
- `scode`  out  2  shift code.
- `acode`  out  3  ALU code.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `halted`  out  1  in HALT state.
- `fault`  out  1  in FAULT state (sticky).

## Operation
- Decode uses latched `ir` (19 bits, loaded in FETCH):
  - [18:17]=00 R-ALU: `acode`=[16:14].
  - 01 I-ALU: `acode`=[16:14], `alu_src`=1.
  - [18:16]=100: [15:14] 00 LW, 01 SW.
  - 101: [15:14] 00 BZ, 01 BNZ.
  - 110: shift, `scode`=[15:14], `is_shift`=1.
  - 111: [15:14] 00 JMP, 01 JSB, 10 RET, 11 HALT.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT. Reset state is FETCH.
- FETCH:
  - If `run`=0, stay.
  - Else latch `ir` and go to DECODE.
- DECODE: always go to EXECUTE. HALT opcode goes to HALT instead, with `pc_write`=0.
- EXECUTE:
  - ALU/shift: go to WRITEBACK, and latch `zero` into `zflag`.
  - LW/SW: go to MEM.
  - Branch: `pc_write`=1 and `branch`=1. `pc_src`=11 if taken (BZ: `zflag`=1; BNZ: `zflag`=0), else 00. Then FETCH.
  - JMP: `pc_src`=01, `pc_write`=1, then FETCH.
  - JSB: `stack_push`=1, `pc_src`=01, `pc_write`=1, then FETCH.
  - RET: `stack_pop`=1, `pc_src`=10, `pc_write`=1, then FETCH.
- MEM:
  - SW: `reg2_read_source`=1, `mem_read_write`=1, `pc_write`=1 (`pc_src`=00), then FETCH.
  - LW: go to WRITEBACK.
- WRITEBACK: `reg_read_write`=1, `mem_or_alu`=1 for LW, `pc_write`=1 (`pc_src`=00), then FETCH.
- Stack fault: if `stack_overflow`=1 in a JSB/RET EXECUTE cycle:
  - `pc_write` is forced 0 that cycle, and the state goes to FAULT.
  - `instr_done` does not pulse.
- HALT and FAULT are left only by `rst`. All write strobes are 0 in both.
- Mode controls (`alu_src`, `is_shift`, `acode`, `scode`, `mem_or_alu`, `reg2_read_source`) are held constant from EXECUTE through the final state of the instruction.
- Write strobes (`reg_read_write`, `mem_read_write`, `stack_push`, `stack_pop`, `pc_write`) are high for exactly one cycle.

## Timing
- Reset values:
  - All outputs are 0, `pc_src`=00.
  - `ir`=0 and `zflag`=0; state is FETCH.
  - `halted`=0, `fault`=0.
- Latency from FETCH entry to retire (`instr_done` in the `pc_write` cycle):
  - ALU/shift: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/jump/call/ret: 3 cycles.
- `rst` mid-instruction:
  - Aborts next edge. Any strobe asserted in the reset cycle is suppressed (outputs are forced 0 while `rst`=1).
  - No partial write completes after the edge.
- `run` deasserted mid-instruction: the current instruction completes, and the controller parks in FETCH.
- `zflag` is updated only by ALU/shift instructions. Branches, loads and stores leave it unchanged.
- `run`=1 with `rst`=1: `rst` wins.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum;
  - opcode field constants (class, LW/SW, BZ/BNZ, JMP/JSB/RET/HALT);
  - `pc_src` encodings (PC_INC, PC_ABS, PC_STACK, PC_REL);
  - a decoded-instruction struct.
- One sub-module is natural: `mips_decoder`, combinational from `ir` to the decoded struct. The FSM and output logic stay in `mips_mc_controller`.

## Test plan
- Reset then `run`=1, instruction R-ALU acode=010:
  - `reg_read_write` pulses in cycle 4 and `pc_write` in the same cycle with `pc_src`=00.
  - `instr_done`=1 once.
- LW (100_00):
  - MEM in cycle 4, WRITEBACK in cycle 5 with `mem_or_alu`=1 and `reg_read_write`=1.
  - `mem_read_write` stays 0 throughout.
- ALU result zero (`zero`=1 in EXECUTE), then BZ offset 8'hFE:
  - `pc_src`=11 with `pc_write`=1 in cycle 3.
  - A following BNZ gives `pc_src`=00.
- JSB with `stack_overflow`=1:
  - `stack_push`=1 and `pc_write`=0 that cycle.
  - Next cycle `fault`=1, and it stays 1 with `run`=1 until `rst`.
- HALT opcode: `halted`=1 from cycle 3. No strobes afterwards, and `rst` returns the controller to FETCH.
- `rst` asserted during the SW MEM cycle: `mem_read_write`=0 in that cycle, and all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// opcode fields, PC source selects and the decoded-instruction record.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT,
    S_FAULT
  } state_t;

  // Instruction class in ir[18:17] (ALU forms) or group in ir[18:16].
  localparam logic [1:0] CLS_RALU  = 2'b00;
  localparam logic [1:0] CLS_IALU  = 2'b01;
  localparam logic [2:0] GRP_MEM   = 3'b100;
  localparam logic [2:0] GRP_BR    = 3'b101;
  localparam logic [2:0] GRP_SHIFT = 3'b110;
  localparam logic [2:0] GRP_CTRL  = 3'b111;

  // Sub-opcodes in ir[15:14].
  localparam logic [1:0] MEM_LW  = 2'b00;
  localparam logic [1:0] MEM_SW  = 2'b01;
  localparam logic [1:0] BR_BZ   = 2'b00;
  localparam logic [1:0] BR_BNZ  = 2'b01;
  localparam logic [1:0] CT_JMP  = 2'b00;
  localparam logic [1:0] CT_JSB  = 2'b01;
  localparam logic [1:0] CT_RET  = 2'b10;
  localparam logic [1:0] CT_HALT = 2'b11;

  // PC source select driven to the datapath.
  localparam logic [1:0] PC_INC   = 2'b00;
  localparam logic [1:0] PC_ABS   = 2'b01;
  localparam logic [1:0] PC_STACK = 2'b10;
  localparam logic [1:0] PC_REL   = 2'b11;

  typedef struct packed {
    logic       is_alu;    // R-ALU or I-ALU
    logic       alu_src;   // immediate operand
    logic       is_shift;
    logic       is_lw;
    logic       is_sw;
    logic       is_bz;
    logic       is_bnz;
    logic       is_jmp;
    logic       is_jsb;
    logic       is_ret;
    logic       is_halt;
    logic [2:0] acode;
    logic [1:0] scode;
  } decoded_t;

endpackage

// File: rtl/mips_decoder.sv
// Combinational decode of the latched instruction register.
module mips_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [18:0] ir,
  output decoded_t    dec
);

  // Classify the instruction; reserved sub-opcodes decode to nothing.
  always_comb begin
    dec = '0;
    if (ir[18:17] == CLS_RALU) begin
      dec.is_alu = 1'b1;
      dec.acode  = ir[16:14];
    end else if (ir[18:17] == CLS_IALU) begin
      dec.is_alu  = 1'b1;
      dec.alu_src = 1'b1;
      dec.acode   = ir[16:14];
    end else begin
      case (ir[18:16])
        GRP_MEM: begin
          dec.is_lw = (ir[15:14] == MEM_LW);
          dec.is_sw = (ir[15:14] == MEM_SW);
        end
        GRP_BR: begin
          dec.is_bz  = (ir[15:14] == BR_BZ);
          dec.is_bnz = (ir[15:14] == BR_BNZ);
        end
        GRP_SHIFT: begin
          dec.is_shift = 1'b1;
          dec.scode    = ir[15:14];
        end
        GRP_CTRL: begin
          dec.is_jmp  = (ir[15:14] == CT_JMP);
          dec.is_jsb  = (ir[15:14] == CT_JSB);
          dec.is_ret  = (ir[15:14] == CT_RET);
          dec.is_halt = (ir[15:14] == CT_HALT);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with HALT and
// a sticky stack-fault stop. Every write strobe fires once per instruction.
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [18:0] instruction,
  input  logic        zero,
  input  logic        stack_overflow,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg2_read_source,
  output logic        branch,
  output logic        mem_read_write,
  output logic        mem_or_alu,
  output logic        is_shift,
  output logic        alu_src,
  output logic        reg_read_write,
  output logic        stack_push,
  output logic        stack_pop,
  output logic [1:0]  scode,
  output logic [2:0]  acode,
  output logic        instr_done,
  output logic        halted,
  output logic        fault
);

  state_t      state;
  state_t      next_state;
  logic [18:0] ir;
  logic        zflag;
  decoded_t    dec;
  logic        taken;

  mips_decoder u_decoder (
    .ir  (ir),
    .dec (dec)
  );

  assign taken = (dec.is_bz && zflag) || (dec.is_bnz && !zflag);

  // State, instruction register and zero flag; zflag follows ALU/shift only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
      zflag <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && run)
        ir <= instruction;
      if (state == S_EXECUTE && (dec.is_alu || dec.is_shift))
        zflag <= zero;
    end
  end

  // Next-state and control outputs; everything is forced low during reset.
  always_comb begin
    next_state       = state;
    pc_write         = 1'b0;
    pc_src           = PC_INC;
    reg2_read_source = 1'b0;
    branch           = 1'b0;
    mem_read_write   = 1'b0;
    mem_or_alu       = 1'b0;
    is_shift         = 1'b0;
    alu_src          = 1'b0;
    reg_read_write   = 1'b0;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    scode            = 2'b00;
    acode            = 3'b000;
    halted           = 1'b0;
    fault            = 1'b0;

    // Mode controls stay steady from EXECUTE until the instruction retires.
    if (state == S_EXECUTE || state == S_MEM || state == S_WRITEBACK) begin
      alu_src          = dec.alu_src;
      is_shift         = dec.is_shift;
      acode            = dec.acode;
      scode            = dec.scode;
      mem_or_alu       = dec.is_lw;
      reg2_read_source = dec.is_sw;
    end

    case (state)
      S_FETCH: begin
        if (run)
          next_state = S_DECODE;
      end
      S_DECODE: begin
        next_state = dec.is_halt ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        next_state = S_FETCH;
        if (dec.is_alu || dec.is_shift) begin
          next_state = S_WRITEBACK;
        end else if (dec.is_lw || dec.is_sw) begin
          next_state = S_MEM;
        end else if (dec.is_bz || dec.is_bnz) begin
          branch   = 1'b1;
          pc_write = 1'b1;
          pc_src   = taken ? PC_REL : PC_INC;
        end else if (dec.is_jmp) begin
          pc_write = 1'b1;
          pc_src   = PC_ABS;
        end else if (dec.is_jsb) begin
          stack_push = 1'b1;
          pc_src     = PC_ABS;
          pc_write   = !stack_overflow;
          if (stack_overflow)
            next_state = S_FAULT;
        end else if (dec.is_ret) begin
          stack_pop = 1'b1;
          pc_src    = PC_STACK;
          pc_write  = !stack_overflow;
          if (stack_overflow)
            next_state = S_FAULT;
        end else begin
          // Reserved encodings retire as a no-op.
          pc_write = 1'b1;
        end
      end
      S_MEM: begin
        if (dec.is_sw) begin
          mem_read_write = 1'b1;
          pc_write       = 1'b1;
          next_state     = S_FETCH;
        end else begin
          next_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        reg_read_write = 1'b1;
        pc_write       = 1'b1;
        next_state     = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: next_state = S_FETCH;
    endcase

    if (rst) begin
      pc_write         = 1'b0;
      pc_src           = PC_INC;
      reg2_read_source = 1'b0;
      branch           = 1'b0;
      mem_read_write   = 1'b0;
      mem_or_alu       = 1'b0;
      is_shift         = 1'b0;
      alu_src          = 1'b0;
      reg_read_write   = 1'b0;
      stack_push       = 1'b0;
      stack_pop        = 1'b0;
      scode            = 2'b00;
      acode            = 3'b000;
      halted           = 1'b0;
      fault            = 1'b0;
    end
  end

  assign instr_done = pc_write;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for the multi-cycle MIPS controller.
module tb_mips_mc_controller;

  logic        clk;
  logic        rst;
  logic        run;
  logic [18:0] instruction;
  logic        zero;
  logic        stack_overflow;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg2_read_source;
  logic        branch;
  logic        mem_read_write;
  logic        mem_or_alu;
  logic        is_shift;
  logic        alu_src;
  logic        reg_read_write;
  logic        stack_push;
  logic        stack_pop;
  logic [1:0]  scode;
  logic [2:0]  acode;
  logic        instr_done;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [4:0]  strobes;
  logic [19:0] all_out;

  assign strobes = {reg_read_write, mem_read_write, stack_push, stack_pop, pc_write};
  assign all_out = {pc_write, pc_src, reg2_read_source, branch, mem_read_write,
                    mem_or_alu, is_shift, alu_src, reg_read_write, stack_push,
                    stack_pop, scode, acode, instr_done, halted, fault};

  mips_mc_controller dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .instruction      (instruction),
    .zero             (zero),
    .stack_overflow   (stack_overflow),
    .pc_write         (pc_write),
    .pc_src           (pc_src),
    .reg2_read_source (reg2_read_source),
    .branch           (branch),
    .mem_read_write   (mem_read_write),
    .mem_or_alu       (mem_or_alu),
    .is_shift         (is_shift),
    .alu_src          (alu_src),
    .reg_read_write   (reg_read_write),
    .stack_push       (stack_push),
    .stack_pop        (stack_pop),
    .scode            (scode),
    .acode            (acode),
    .instr_done       (instr_done),
    .halted           (halted),
    .fault            (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: latch ins, pass DECODE, arrive at the start of EXECUTE.
  task automatic run_to_execute(input logic [18:0] ins);
    instruction = ins;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; instruction = '0; zero = 1'b0; stack_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", all_out, 0);
    rst = 1'b0;
    #1;
    chk("idle_fetch", all_out, 0);

    // R-ALU acode=010
    instruction = 19'h08000; run = 1'b1;
    #1; chk("alu_c1_strb", strobes, 0);
    step(); instruction = 19'h7FFFF; run = 1'b0;
    #1; chk("alu_c2_strb", strobes, 0);
    step(); zero = 1'b0;
    #1; chk("alu_c3_strb", strobes, 0); chk("alu_c3_acode", acode, 3'b010);
    step();
    #1; chk("alu_c4_strb", strobes, 5'b10001); chk("alu_c4_src", pc_src, 0);
    chk("alu_c4_done", instr_done, 1); chk("alu_c4_acode", acode, 3'b010);
    step();
    #1; chk("alu_c5_idle", {strobes, instr_done}, 0);

    // LW with zero=1 in EXECUTE: zflag must stay 0
    run_to_execute(19'h40000); zero = 1'b1;
    #1; chk("lw_c3_strb", strobes, 0); chk("lw_c3_moa", mem_or_alu, 1);
    step(); zero = 1'b0;
    #1; chk("lw_c4_strb", strobes, 0); chk("lw_c4_moa", mem_or_alu, 1);
    step();
    #1; chk("lw_c5_strb", strobes, 5'b10001); chk("lw_c5_moa", mem_or_alu, 1);
    chk("lw_c5_done", instr_done, 1);
    step();

    // BNZ with zflag=0: taken
    run_to_execute(19'h540FE); zero = 1'b1;
    #1; chk("bnz1_src", pc_src, 2'b11); chk("bnz1_strb", strobes, 5'b00001);
    chk("bnz1_branch", branch, 1); chk("bnz1_done", instr_done, 1);
    step(); zero = 1'b0;

    // I-ALU acode=101 with zero=1: sets zflag
    run_to_execute(19'h34000); zero = 1'b1;
    #1; chk("ialu_src", alu_src, 1); chk("ialu_acode", acode, 3'b101);
    step(); zero = 1'b0;
    #1; chk("ialu_c4_strb", strobes, 5'b10001); chk("ialu_c4_src", alu_src, 1);
    step();

    // BZ offset FE: taken
    run_to_execute(19'h500FE);
    #1; chk("bz_src", pc_src, 2'b11); chk("bz_strb", strobes, 5'b00001);
    chk("bz_branch", branch, 1);
    step();

    // BNZ after zflag=1: not taken
    run_to_execute(19'h540FE);
    #1; chk("bnz2_src", pc_src, 2'b00); chk("bnz2_strb", strobes, 5'b00001);
    step();

    // Shift scode=10
    run_to_execute(19'h68000);
    #1; chk("sh_c3_shift", {is_shift, scode}, 3'b110); chk("sh_c3_strb", strobes, 0);
    step();
    #1; chk("sh_c4_strb", strobes, 5'b10001); chk("sh_c4_shift", {is_shift, scode}, 3'b110);
    step();

    // SW
    run_to_execute(19'h44000);
    #1; chk("sw_c3_r2", reg2_read_source, 1); chk("sw_c3_strb", strobes, 0);
    step();
    #1; chk("sw_c4_strb", strobes, 5'b01001); chk("sw_c4_r2", reg2_read_source, 1);
    chk("sw_c4_done", instr_done, 1);
    step();

    // JMP
    run_to_execute(19'h70ABC);
    #1; chk("jmp_src", pc_src, 2'b01); chk("jmp_strb", strobes, 5'b00001);
    step();

    // RET without fault
    run_to_execute(19'h78000);
    #1; chk("ret_src", pc_src, 2'b10); chk("ret_strb", strobes, 5'b00011);
    step();

    // rst during SW MEM
    run_to_execute(19'h44000);
    step(); rst = 1'b1;
    #1; chk("swrst_mrw", mem_read_write, 0); chk("swrst_all", all_out, 0);
    step(); rst = 1'b0;
    #1; chk("swrst_after", all_out, 0);
    step();
    #1; chk("swrst_idle", all_out, 0);

    // HALT
    instruction = 19'h7C000; run = 1'b1;
    step();
    #1; chk("halt_c2_strb", strobes, 0);
    step();
    #1; chk("halt_c3", halted, 1); chk("halt_c3_strb", strobes, 0);
    step();
    #1; chk("halt_c4", halted, 1); chk("halt_c4_strb", strobes, 0);
    instruction = 19'h70123;
    rst = 1'b1;
    step(); rst = 1'b0;
    #1; chk("halt_rst_out", all_out, 0);
    step(); run = 1'b0;
    step();
    #1; chk("post_halt_jmp", {pc_write, pc_src}, 3'b101);
    step();

    // JSB with stack overflow
    run_to_execute(19'h74123); stack_overflow = 1'b1;
    #1; chk("jsb_strb", strobes, 5'b00100); chk("jsb_done", instr_done, 0);
    chk("jsb_src", pc_src, 2'b01);
    step(); stack_overflow = 1'b0; run = 1'b1;
    #1; chk("fault_c4", fault, 1); chk("fault_c4_strb", strobes, 0);
    repeat (3) step();
    #1; chk("fault_sticky", {fault, strobes}, 6'b100000);
    rst = 1'b1;
    step(); rst = 1'b0; run = 1'b0;
    #1; chk("fault_cleared", fault, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
